// File: rtl/ula_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ula_operand_sequencer
//  Description : Collects operand A, operand B and a 3-bit opcode, one after
//                another, from a shared switch bus. Each capture is triggered
//                by a press of a raw load button. Once all three are held,
//                presents them as a complete operation with a valid level
//                and a one-cycle start pulse.
//
//  Ports
//    clk      in   system clock, rising edge
//    rst_n    in   asynchronous active-low reset
//    data_in  in   shared switch bus (WIDTH)
//    load     in   raw push-button level, asynchronous, active high
//    clear    in   synchronous abort, active high
//    A, B     out  registered operands (WIDTH)
//    Opcode   out  registered opcode, low 3 bits of data_in
//    valid    out  high while A/B/Opcode form a complete operation
//    start    out  one-cycle pulse when an operation becomes complete
//    phase    out  current sequencer state, for status LEDs
//
//  Revision    : 1.0  initial release
// ============================================================================
module ula_operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int HOLDOFF = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       Opcode,
  output logic             valid,
  output logic             start,
  output logic [1:0]       phase
);

  // A HOLDOFF of 0 would give a zero-width counter; keep at least one bit.
  localparam int c_hold_w = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  logic                r_s1;
  logic                r_s2;
  logic                r_s2_d;
  logic [c_hold_w-1:0] r_hold_cnt;
  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [2:0]          r_opcode;
  logic                r_valid;
  logic                r_start;

  logic                w_edge;
  logic                w_evt;

  // Button synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= load;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s2_d;
  // Edges seen while the hold-off window is open are dropped, not queued.
  assign w_evt  = w_edge & (r_hold_cnt == '0);

  // Hold-off window; an event swallowed by clear still restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_evt) begin
      r_hold_cnt <= c_hold_w'(HOLDOFF);
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - c_hold_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= WAIT_A;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (clear) begin
        r_state  <= WAIT_A;
        r_a      <= '0;
        r_b      <= '0;
        r_opcode <= '0;
        r_valid  <= 1'b0;
      end else if (w_evt) begin
        case (r_state)
          WAIT_A: begin
            r_a     <= data_in;
            r_state <= WAIT_B;
          end
          WAIT_B: begin
            r_b     <= data_in;
            r_state <= WAIT_OP;
          end
          WAIT_OP: begin
            r_opcode <= data_in[2:0];
            r_valid  <= 1'b1;
            r_start  <= 1'b1;
            r_state  <= READY;
          end
          READY: begin
            // Next operation begins; B and Opcode keep their old values
            // until they are overwritten by their own load events.
            r_a     <= data_in;
            r_valid <= 1'b0;
            r_state <= WAIT_B;
          end
          default: r_state <= WAIT_A;
        endcase
      end
    end
  end

  assign A      = r_a;
  assign B      = r_b;
  assign Opcode = r_opcode;
  assign valid  = r_valid;
  assign start  = r_start;
  assign phase  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ula_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula_operand_sequencer
//  Description : Self-checking bench. Two sequencers (HOLDOFF 0 and 4) share
//                one stimulus stream; a timestamp-based reference model
//                predicts every output on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ula_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       load = 1'b0;
  logic       clear = 1'b0;

  logic [7:0] a0, b0, a4, b4;
  logic [2:0] op0, op4;
  logic       v0, s0, v4, s4;
  logic [1:0] ph0, ph4;

  ula_operand_sequencer #(.WIDTH(8), .HOLDOFF(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .clear(clear),
    .A(a0), .B(b0), .Opcode(op0), .valid(v0), .start(s0), .phase(ph0)
  );

  ula_operand_sequencer #(.WIDTH(8), .HOLDOFF(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .clear(clear),
    .A(a4), .B(b4), .Opcode(op4), .valid(v4), .start(s4), .phase(ph4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: operation progress per instance, plus the edge index
  // of the last accepted load event for hold-off arithmetic.
  int         hold_of [2];
  int         m_last  [2];
  int         m_phase [2];
  logic [7:0] m_a     [2];
  logic [7:0] m_b     [2];
  logic [2:0] m_op    [2];
  logic       m_valid [2];
  logic       m_start [2];
  int         pend[$];      // edge indices at which a detected press takes effect
  logic       prev_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i]  = -1000000;
      m_phase[i] = 0;
      m_a[i]     = '0;
      m_b[i]     = '0;
      m_op[i]    = '0;
      m_valid[i] = 1'b0;
      m_start[i] = 1'b0;
    end
    pend.delete();
    prev_load = 1'b0;
  endtask

  task automatic model_edge(input int i, input bit due, input bit clr, input logic [7:0] d);
    bit acc;
    m_start[i] = 1'b0;
    // A press is honoured only if more than HOLDOFF edges passed since the last one.
    acc = due && ((cyc - m_last[i]) > hold_of[i]);
    if (acc) m_last[i] = cyc;
    if (clr) begin
      m_phase[i] = 0; m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_valid[i] = 1'b0;
    end else if (acc) begin
      case (m_phase[i])
        0: begin m_a[i] = d; m_phase[i] = 1; end
        1: begin m_b[i] = d; m_phase[i] = 2; end
        2: begin m_op[i] = d[2:0]; m_valid[i] = 1'b1; m_start[i] = 1'b1; m_phase[i] = 3; end
        default: begin m_a[i] = d; m_valid[i] = 1'b0; m_phase[i] = 1; end
      endcase
    end
  endtask

  function automatic logic [31:0] expv(input int i);
    return {9'd0, m_a[i], m_b[i], m_op[i], m_valid[i], m_start[i], m_phase[i][1:0]};
  endfunction

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic step();
    bit due;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      // Press sampled at edge n lands in the target register at edge n+2.
      if (load && !prev_load) pend.push_back(cyc + 2);
      prev_load = load;
      due = 1'b0;
      if (pend.size() > 0 && pend[0] == cyc) begin
        due = 1'b1;
        void'(pend.pop_front());
      end
      for (int i = 0; i < 2; i++) model_edge(i, due, clear, data_in);
    end
    @(negedge clk);
    chk($sformatf("cyc%0d_hold0", cyc), {9'd0, a0, b0, op0, v0, s0, ph0}, expv(0));
    chk($sformatf("cyc%0d_hold4", cyc), {9'd0, a4, b4, op4, v4, s4, ph4}, expv(1));
  endtask

  task automatic pulse(input logic [7:0] d, input int hi, input int lo);
    data_in = d;
    load = 1'b1;
    repeat (hi) step();
    load = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    hold_of[0] = 0;
    hold_of[1] = 4;
    model_reset();

    // Reset state
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    chk("reset_phase", {30'd0, ph0}, 32'd0);

    // Basic sequence
    pulse(8'h5A, 3, 8);
    chk("seq_a_phase", {30'd0, ph0}, 32'd1);
    pulse(8'h3C, 3, 8);
    chk("seq_b_phase", {30'd0, ph4}, 32'd2);
    pulse(8'h06, 3, 8);
    chk("seq_a", {24'd0, a0}, 32'h5A);
    chk("seq_b", {24'd0, b0}, 32'h3C);
    chk("seq_op", {29'd0, op0}, 32'd6);
    chk("seq_valid", {31'd0, v4}, 32'd1);

    // Reload from READY, then hold-off boundary
    pulse(8'hFF, 1, 2);
    chk("ready_reload_a", {24'd0, a4}, 32'hFF);
    chk("ready_reload_b", {24'd0, b4}, 32'h3C);
    chk("ready_reload_valid", {31'd0, v4}, 32'd0);
    chk("ready_reload_phase", {30'd0, ph4}, 32'd1);
    pulse(8'h11, 1, 1);          // lands 3 edges after the last accept
    pulse(8'h22, 1, 8);          // lands 5 edges after: first legal slot
    chk("holdoff_phase4", {30'd0, ph4}, 32'd2);
    chk("holdoff_b4", {24'd0, b4}, 32'h22);
    chk("holdoff_phase0", {30'd0, ph0}, 32'd3);
    chk("holdoff_op0", {29'd0, op0}, 32'd2);

    // Clear in the same cycle as an event arriving in WAIT_OP
    data_in = 8'h07;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk("clear_outputs4", {9'd0, a4, b4, op4, v4, s4, ph4}, 32'd0);
    chk("clear_outputs0", {9'd0, a0, b0, op0, v0, s0, ph0}, 32'd0);
    repeat (8) step();

    // Asynchronous reset mid-WAIT_B with load held high
    pulse(8'h77, 3, 8);
    data_in = 8'h88;
    load = 1'b1;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hold0", {9'd0, a0, b0, op0, v0, s0, ph0}, 32'd0);
    chk("async_rst_hold4", {9'd0, a4, b4, op4, v4, s4, ph4}, 32'd0);
    model_reset();
    repeat (2) step();
    data_in = 8'h99;
    rst_n = 1'b1;
    repeat (8) step();
    chk("post_rst_a", {24'd0, a4}, 32'h99);
    chk("post_rst_phase", {30'd0, ph0}, 32'd1);
    load = 1'b0;
    repeat (8) step();

    // Long press gives one capture; opcode uses only the low bits
    pulse(8'h44, 50, 8);
    chk("long_b", {24'd0, b0}, 32'h44);
    chk("long_phase", {30'd0, ph4}, 32'd2);
    pulse(8'hFD, 3, 8);
    chk("op_low_bits", {29'd0, op4}, 32'd5);
    chk("op_valid", {31'd0, v0}, 32'd1);

    // Randomised presses with occasional aborts
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear = 1'b1;
        step();
        clear = 1'b0;
      end
      pulse(8'($urandom), $urandom_range(1, 5), $urandom_range(1, 6));
    end
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
